// File: rtl/piso_serializer_if.sv
// Parallel-word valid/ready handshake into the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the downstream single-bit serial register.
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_,
    piso_serializer_if.slave    in_if,
    output logic                sout,
    output logic                sout_valid,
    output logic                sout_first,
    output logic                sout_last,
    output logic                busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic             r_valid;
    logic             r_first;
    logic             r_last;
    logic             r_busy;
    logic             w_ready;
    logic             w_accept;
    logic             w_head;

    // r_last marks the frame's final bit, which is also the only mid-frame reload slot
    assign w_ready  = rst_ & ((r_state == IDLE) | r_last);
    assign w_accept = in_if.in_valid & w_ready;
    assign in_if.in_ready = w_ready;

    always_comb begin
        w_head = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
        sout   = (r_state == SHIFT) & w_head;
`ifdef PISO_PARITY_EN
        sout   = sout | ((r_state == PAR) & r_par);
`endif
    end

    assign sout_valid = r_valid;
    assign sout_first = r_first;
    assign sout_last  = r_last;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_sh    <= in_if.in_data;
            r_cnt   <= '0;
`ifdef PISO_PARITY_EN
            r_par   <= ^in_if.in_data;
`endif
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (r_cnt == LAST) begin
`ifdef PISO_PARITY_EN
                        r_state <= PAR;
                        r_first <= 1'b0;
                        r_last  <= 1'b1;
`else
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_sh    <= MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        r_first <= 1'b0;
`ifdef PISO_PARITY_EN
                        r_last  <= 1'b0;
`else
                        r_last  <= (r_cnt == PENULT);
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_first <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_first <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (MSB-first and LSB-first instances).
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic s0, v0, f0, l0, b0;
    logic s1, v1, f1, l1, b1;

    piso_serializer_if #(.WIDTH(8)) if0 ();
    piso_serializer_if #(.WIDTH(8)) if1 ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_(rst_), .in_if(if0),
        .sout(s0), .sout_valid(v0), .sout_first(f0), .sout_last(l0), .busy(b0)
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_(rst_), .in_if(if1),
        .sout(s1), .sout_valid(v1), .sout_first(f1), .sout_last(l1), .busy(b1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        if0.in_data = '0; if0.in_valid = 1'b0;
        if1.in_data = '0; if1.in_valid = 1'b0;
        rst_ = 1'b0;
        #12;
        checks++;
        if ({s0, v0, f0, l0, b0, if0.in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 000000", {s0, v0, f0, l0, b0, if0.in_ready});
        end
        rst_ = 1'b1;
        tick();
        checks++;
        if ({if0.in_ready, if1.in_ready, b0, v0} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got %b want 1100", {if0.in_ready, if1.in_ready, b0, v0});
        end
    endtask

    task automatic test_msb_a5();
        logic [7:0] w;
        w = 8'hA5;
        if0.in_data = w; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({s0, v0, f0, l0, b0} !== {w[8-c], 1'b1, c == 1, c == 8, 1'b1}) begin
                errors++;
                $display("FAIL msb_a5 c%0d: got s/v/f/l/b=%b want %b", c, {s0, v0, f0, l0, b0},
                         {w[8-c], 1'b1, c == 1, c == 8, 1'b1});
            end
            tick();
        end
        checks++;
        if ({b0, v0, if0.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL msb_a5_idle: got b/v/rdy=%b want 001", {b0, v0, if0.in_ready});
        end
    endtask

    task automatic test_lsb_01();
        logic [7:0] w;
        w = 8'h01;
        if1.in_data = w; if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({s1, v1, if1.in_ready, l1} !== {w[c-1], 1'b1, c == 8, c == 8}) begin
                errors++;
                $display("FAIL lsb_01 c%0d: got s/v/rdy/l=%b want %b", c, {s1, v1, if1.in_ready, l1},
                         {w[c-1], 1'b1, c == 8, c == 8});
            end
            tick();
        end
        checks++;
        if ({b1, v1} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_01_idle: got b/v=%b want 00", {b1, v1});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        int acc;
        exp = 16'b1111000000001111;
        acc = 0;
        if0.in_data = 8'hF0; if0.in_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            if (if0.in_valid && if0.in_ready) acc++;
            tick();
            if (acc == 1) if0.in_data = 8'h0F;
            if (acc == 2) if0.in_valid = 1'b0;
            checks++;
            if (c <= 16) begin
                if ({s0, v0, f0} !== {exp[16-c], 1'b1, (c == 1) || (c == 9)}) begin
                    errors++;
                    $display("FAIL b2b c%0d: got s/v/f=%b want %b", c, {s0, v0, f0},
                             {exp[16-c], 1'b1, (c == 1) || (c == 9)});
                end
            end else if ({v0, b0} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_idle: got v/b=%b want 00", {v0, b0});
            end
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 2", acc);
        end
    endtask

    task automatic test_reset_midframe();
        if0.in_data = 8'hFF; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({s0, v0, b0} !== 3'b111) begin
            errors++;
            $display("FAIL midrst_pre: got s/v/b=%b want 111", {s0, v0, b0});
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if ({s0, v0, f0, l0, b0, if0.in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outs: got %b want 000000", {s0, v0, f0, l0, b0, if0.in_ready});
        end
        tick();
        #2 rst_ = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({if0.in_ready, v0, s0, b0} !== 4'b1000) begin
                errors++;
                $display("FAIL midrst_after c%0d: got rdy/v/s/b=%b want 1000", c, {if0.in_ready, v0, s0, b0});
            end
        end
    endtask

    task automatic test_ignored_pulse();
        logic [7:0] w;
        w = 8'hC3;
        if0.in_data = w; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                if0.in_data = 8'h00; if0.in_valid = 1'b1;
                checks++;
                if (if0.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ign_ready: got %b want 0", if0.in_ready);
                end
            end
            if (c == 4) if0.in_valid = 1'b0;
            checks++;
            if ({s0, v0} !== {w[8-c], 1'b1}) begin
                errors++;
                $display("FAIL ign_frame c%0d: got s/v=%b want %b", c, {s0, v0}, {w[8-c], 1'b1});
            end
            tick();
        end
        checks++;
        if ({b0, v0} !== 2'b00) begin
            errors++;
            $display("FAIL ign_idle: got b/v=%b want 00", {b0, v0});
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [8:0] exp;
        exp = 9'b000001111;
        if0.in_data = 8'h07; if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if ({s0, v0, l0, if0.in_ready} !== {exp[9-c], 1'b1, c == 9, c == 9}) begin
                errors++;
                $display("FAIL parity c%0d: got s/v/l/rdy=%b want %b", c, {s0, v0, l0, if0.in_ready},
                         {exp[9-c], 1'b1, c == 9, c == 9});
            end
            tick();
        end
        checks++;
        if ({b0, v0} !== 2'b00) begin
            errors++;
            $display("FAIL parity_idle: got b/v=%b want 00", {b0, v0});
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PISO_PARITY_EN
        test_parity();
        test_reset_midframe();
`else
        test_msb_a5();
        test_lsb_01();
        test_back_to_back();
        test_reset_midframe();
        test_ignored_pulse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out shift stage that sits directly upstream of the single-bit serial register stage and drives its d input.
- Accepts a WIDTH-bit word over a valid/ready handshake, then emits it one bit per clk with framing strobes.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  parallel word to serialize
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- sout  output  1  serial data bit; feeds the downstream serial stage d
- sout_valid  output  1  sout carries a frame bit this cycle
- sout_first  output  1  high on the first bit of a frame
- sout_last  output  1  high on the final bit of a frame
- busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst_ low forces IDLE asynchronously.
  - Shift register, bit counter and parity flop are cleared to 0.
  - sout, sout_valid, sout_first, sout_last and busy are all 0.
  - in_ready is forced 0 while rst_ is low.
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits being emitted.
  - PAR: parity bit being emitted; exists only with the optional feature.
- Accept: an accept occurs on a rising edge where in_valid && in_ready.
  - in_data is captured into the shift register.
  - The counter is cleared to 0 and the state becomes SHIFT.
- in_ready = 1 in IDLE, and 1 on the frame's final bit cycle (gapless streaming). It is 0 in every other cycle.
- Latency: the first bit appears on sout in the cycle after the accept edge.
- In SHIFT:
  - sout is the shift-register bit at the head: MSB if MSB_FIRST, else LSB.
  - sout_valid = 1.
  - Each edge shifts by one position, zero-filled, and increments the counter.
  - The counter is $clog2(WIDTH) bits wide and holds 0..WIDTH-1.
- Framing strobes:
  - sout_first = 1 when counter == 0.
  - sout_last = 1 on the final frame bit. Without parity this is counter == WIDTH-1.
- Final data bit (counter == WIDTH-1), no parity:
  - If accepted on the same edge: reload and stay in SHIFT, with no idle cycle between frames.
  - Otherwise: go to IDLE.
- In IDLE: sout = 0, sout_valid = 0, sout_first = 0, sout_last = 0.
- in_data and in_valid are ignored whenever in_ready = 0. The upstream source must hold its word until the accept.
- Reset mid-frame aborts the frame immediately. No remaining bits are emitted after release, and the block returns to IDLE with in_ready = 1.
- All outputs are decoded from registered state only. There is no combinational path from in_valid or in_data to any output, except in_ready's dependency on rst_.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - Even parity of in_data (reduction XOR) is captured at accept.
  - After the WIDTH data bits, state PAR emits the parity bit on sout with sout_valid = 1 and sout_last = 1.
  - The last data bit then has sout_last = 0 and in_ready = 0.
  - in_ready = 1 in PAR, so back-to-back loading occurs during the parity cycle.
  - Frame length is WIDTH+1 cycles.
- When undefined: no PAR state, no parity logic, and frame length is WIDTH cycles.

Test Plan:
- WIDTH=8, MSB_FIRST=1, single in_data=8'hA5 accepted at cycle 0:
  - sout = 1,0,1,0,0,1,0,1 on cycles 1..8, with sout_valid = 1 on those cycles.
  - sout_first on cycle 1 only, sout_last on cycle 8 only.
  - busy and sout_valid are 0 from cycle 9.
- MSB_FIRST=0, in_data=8'h01:
  - sout = 1,0,0,0,0,0,0,0.
  - in_ready = 0 on cycles 1..7 and 1 on cycle 8.
- Back-to-back 8'hF0 then 8'h0F with in_valid held high:
  - 16 contiguous sout_valid cycles, sout = 1111000000001111.
  - sout_first on cycles 1 and 9.
  - Exactly 2 accepts occur.
- Reset mid-frame: assert rst_ low after 3 bits of 8'hFF:
  - All outputs are 0 within the same cycle.
  - After release, in_ready = 1 and sout_valid stays 0 until the next accept.
- in_valid pulsed with new data while in_ready = 0 (mid-frame): the pulse is ignored, and the in-flight frame completes unchanged.
- PISO_PARITY_EN defined, in_data=8'h07:
  - 9-bit frame 0,0,0,0,0,1,1,1 followed by parity bit 1.
  - sout_last on bit 9 only.
  - in_ready is high only on the parity cycle.
